// File: rtl/irq_if.sv
// irq_if: interrupt source, mask and CPU handshake signals between peripherals/CPU and irq_controller
interface irq_if #(
  parameter int NUM_IRQ      = 4,
  parameter int I_ADDR_WIDTH = 10
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  logic [NUM_IRQ-1:0]      irq_src;
  logic [NUM_IRQ-1:0]      irq_en;
  logic                    global_ie;
  logic                    cpu_ack;
  logic                    cpu_reti;
  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;
  logic [ID_W-1:0]         irq_id;
  logic [NUM_IRQ-1:0]      pending;
  logic [NUM_IRQ-1:0]      in_service;
  modport slave (
    input  irq_src, irq_en, global_ie, cpu_ack, cpu_reti,
    output irq, vector, irq_id, pending, in_service
  );
  modport master (
    output irq_src, irq_en, global_ie, cpu_ack, cpu_reti,
    input  irq, vector, irq_id, pending, in_service
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, fixed-priority interrupt controller with ack/reti tracking; define IRQ_NESTING_EN to allow preemption by higher-priority sources
module irq_controller #(
  parameter int NUM_IRQ      = 4,
  parameter int I_ADDR_WIDTH = 10,
  parameter int VECTOR_BASE  = 1
) (
  input  logic clk,
  input  logic reset,
  irq_if.slave bus
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;
  state_t                  r_state, w_next;
  logic [NUM_IRQ-1:0]      r_src_q, r_pending, r_in_service;
  logic [NUM_IRQ-1:0]      w_cand, w_id_oh, w_isr_oh;
  logic [ID_W-1:0]         r_id, w_win_id, w_isr_id;
  logic                    w_win_valid, w_load, w_ack, w_reti;
  logic                    r_irq;
  logic [I_ADDR_WIDTH-1:0] r_vector;
  assign w_cand     = r_pending & bus.irq_en;
  assign w_id_oh    = NUM_IRQ'(1) << r_id;
  assign w_isr_oh   = NUM_IRQ'(1) << w_isr_id;
  assign bus.irq        = r_irq;
  assign bus.vector     = r_vector;
  assign bus.irq_id     = r_id;
  assign bus.pending    = r_pending;
  assign bus.in_service = r_in_service;
  // lowest-index candidate wins; lowest set in-service bit is the one currently being serviced
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_isr_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = ID_W'(i);
      end
      if (r_in_service[i]) w_isr_id = ID_W'(i);
    end
  end
  // next state plus the ack/reti/load strobes; withdrawal outranks a same-cycle ack
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_ack  = 1'b0;
    w_reti = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.global_ie && w_win_valid) begin
          w_next = S_REQ;
          w_load = 1'b1;
        end
      end
      S_REQ: begin
        if (!bus.global_ie || !w_cand[r_id]) begin
          w_next = (|r_in_service) ? S_SERVICE : S_IDLE;
        end else if (bus.cpu_ack) begin
          w_ack  = 1'b1;
          w_next = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (bus.cpu_reti && |r_in_service) begin
          w_reti = 1'b1;
          w_next = ((r_in_service & ~w_isr_oh) == '0) ? S_IDLE : S_SERVICE;
        end
`ifdef IRQ_NESTING_EN
        else if (bus.global_ie && w_win_valid && (w_win_id < w_isr_id)) begin
          w_next = S_REQ;
          w_load = 1'b1;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end
  // state, edge detector, pending/in-service flags and the frozen request outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_src_q      <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_irq        <= 1'b0;
      r_id         <= '0;
      r_vector     <= '0;
    end else begin
      r_state      <= w_next;
      r_src_q      <= bus.irq_src;
      r_pending    <= (r_pending & ~(w_ack ? w_id_oh : '0)) | (bus.irq_src & ~r_src_q);
      r_in_service <= (r_in_service | (w_ack ? w_id_oh : '0)) & ~(w_reti ? w_isr_oh : '0);
      r_irq        <= (w_next == S_REQ);
      if (w_load) begin
        r_id     <= w_win_id;
        r_vector <= I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(w_win_id);
      end
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vector table, async reset check and randomized run against a reference model
module tb_irq_controller;
  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int BASE = 1;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  irq_if #(.NUM_IRQ(N), .I_ADDR_WIDTH(AW)) bus ();
  irq_controller #(.NUM_IRQ(N), .I_ADDR_WIDTH(AW), .VECTOR_BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0] src, en;
    logic       gie, ack, reti, irq;
    logic [9:0] vec;
    logic [1:0] id;
    logic [3:0] pend, ins;
  } vec_t;
  vec_t tbl[30];
  function automatic vec_t row(input logic [3:0] src, input logic [3:0] en, input logic gie,
                               input logic ack, input logic reti, input logic irq, input int vec,
                               input int id, input logic [3:0] pend, input logic [3:0] ins);
    vec_t r;
    r.src = src; r.en = en; r.gie = gie; r.ack = ack; r.reti = reti;
    r.irq = irq; r.vec = 10'(vec); r.id = 2'(id); r.pend = pend; r.ins = ins;
    return r;
  endfunction
  // reference model: sets of pending / in-service sources and a request phase
  bit m_pend[N], m_ins[N], m_prev[N];
  int m_phase, m_id, m_vec;
  bit m_irq;
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_ins[k] = 0; m_prev[k] = 0; end
    m_phase = 0; m_id = 0; m_vec = 0; m_irq = 0;
  endtask
  task automatic model_step();
    int  win = -1;
    bit  any_ins = 0;
    int  clr = -1;
    for (int k = N - 1; k >= 0; k--) if (m_pend[k] && bus.irq_en[k]) win = k;
    for (int k = 0; k < N; k++) any_ins |= m_ins[k];
    if (m_phase == 0) begin
      if (bus.global_ie && win >= 0) begin
        m_phase = 1; m_id = win; m_vec = (BASE + win) % (1 << AW); m_irq = 1;
      end
    end else if (m_phase == 1) begin
      if (!bus.global_ie || !(m_pend[m_id] && bus.irq_en[m_id])) begin
        m_phase = any_ins ? 2 : 0; m_irq = 0;
      end else if (bus.cpu_ack) begin
        clr = m_id; m_ins[m_id] = 1; m_phase = 2; m_irq = 0;
      end
    end else if (bus.cpu_reti && any_ins) begin
      for (int k = 0; k < N; k++) if (m_ins[k]) begin m_ins[k] = 0; break; end
      m_phase = 0;
    end
    if (clr >= 0) m_pend[clr] = 0;
    for (int k = 0; k < N; k++) begin
      if (bus.irq_src[k] && !m_prev[k]) m_pend[k] = 1;
      m_prev[k] = bus.irq_src[k];
    end
  endtask
  function automatic logic [20:0] model_out();
    logic [3:0] p, s;
    for (int k = 0; k < N; k++) begin p[k] = m_pend[k]; s[k] = m_ins[k]; end
    return {m_irq, 10'(m_vec), 2'(m_id), p, s};
  endfunction
  task automatic check(input string nm, input logic [20:0] exp);
    logic [20:0] got;
    got = {bus.irq, bus.vector, bus.irq_id, bus.pending, bus.in_service};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got irq=%b vec=%0d id=%0d pend=%b ins=%b, expected irq=%b vec=%0d id=%0d pend=%b ins=%b",
               nm, got[20], got[19:10], got[9:8], got[7:4], got[3:0],
               exp[20], exp[19:10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask
  initial begin
    //              src      en       gie  ack  reti irq vec id pend     ins
    tbl[0]  = row(4'b0000, 4'b0011, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[1]  = row(4'b0001, 4'b0011, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[2]  = row(4'b0001, 4'b0011, 1, 0, 0, 1, 1, 0, 4'b0001, 4'b0000);
    tbl[3]  = row(4'b0001, 4'b0011, 1, 1, 0, 0, 1, 0, 4'b0000, 4'b0001);
    tbl[4]  = row(4'b0001, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0000, 4'b0001);
    tbl[5]  = row(4'b0001, 4'b0011, 1, 0, 1, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[6]  = row(4'b0000, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[7]  = row(4'b0011, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0011, 4'b0000);
    tbl[8]  = row(4'b0011, 4'b0011, 1, 0, 0, 1, 1, 0, 4'b0011, 4'b0000);
    tbl[9]  = row(4'b0011, 4'b0011, 1, 1, 0, 0, 1, 0, 4'b0010, 4'b0001);
    tbl[10] = row(4'b0011, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0001);
    tbl[11] = row(4'b0011, 4'b0011, 1, 0, 1, 0, 1, 0, 4'b0010, 4'b0000);
    tbl[12] = row(4'b0011, 4'b0011, 1, 0, 0, 1, 2, 1, 4'b0010, 4'b0000);
    tbl[13] = row(4'b0011, 4'b0011, 1, 1, 0, 0, 2, 1, 4'b0000, 4'b0010);
    tbl[14] = row(4'b0011, 4'b0011, 1, 0, 1, 0, 2, 1, 4'b0000, 4'b0000);
    tbl[15] = row(4'b0000, 4'b0011, 0, 0, 0, 0, 2, 1, 4'b0000, 4'b0000);
    tbl[16] = row(4'b0010, 4'b0011, 0, 0, 0, 0, 2, 1, 4'b0010, 4'b0000);
    tbl[17] = row(4'b0010, 4'b0011, 0, 0, 0, 0, 2, 1, 4'b0010, 4'b0000);
    tbl[18] = row(4'b0010, 4'b0011, 1, 0, 0, 1, 2, 1, 4'b0010, 4'b0000);
    tbl[19] = row(4'b0010, 4'b0011, 0, 1, 0, 0, 2, 1, 4'b0010, 4'b0000);
    tbl[20] = row(4'b0010, 4'b0011, 1, 0, 0, 1, 2, 1, 4'b0010, 4'b0000);
    tbl[21] = row(4'b0010, 4'b0011, 1, 1, 0, 0, 2, 1, 4'b0000, 4'b0010);
    tbl[22] = row(4'b0010, 4'b0011, 1, 0, 1, 0, 2, 1, 4'b0000, 4'b0000);
    tbl[23] = row(4'b0000, 4'b0011, 1, 0, 0, 0, 2, 1, 4'b0000, 4'b0000);
    tbl[24] = row(4'b0001, 4'b0011, 1, 0, 0, 0, 2, 1, 4'b0001, 4'b0000);
    tbl[25] = row(4'b0001, 4'b0011, 1, 0, 0, 1, 1, 0, 4'b0001, 4'b0000);
    tbl[26] = row(4'b0001, 4'b0011, 1, 1, 0, 0, 1, 0, 4'b0000, 4'b0001);
    tbl[27] = row(4'b0011, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0001);
    tbl[28] = row(4'b0011, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0001);
    tbl[29] = row(4'b0011, 4'b0011, 1, 1, 0, 0, 1, 0, 4'b0010, 4'b0001);
    bus.irq_src = '0; bus.irq_en = '0; bus.global_ie = 0; bus.cpu_ack = 0; bus.cpu_reti = 0;
    model_reset();
    #12 reset = 1'b1;
    check("reset", '0);
    for (int i = 0; i < 30; i++) begin
      bus.irq_src = tbl[i].src; bus.irq_en = tbl[i].en; bus.global_ie = tbl[i].gie;
      bus.cpu_ack = tbl[i].ack; bus.cpu_reti = tbl[i].reti;
      @(posedge clk); #1;
      check($sformatf("row%0d", i), {tbl[i].irq, tbl[i].vec, tbl[i].id, tbl[i].pend, tbl[i].ins});
    end
    #3 reset = 1'b0;
    #1 check("async_reset", '0);
    bus.irq_src = '0; bus.irq_en = 4'b1111; bus.global_ie = 0; bus.cpu_ack = 0; bus.cpu_reti = 0;
    @(negedge clk); #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.irq_src   = bus.irq_src ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) bus.irq_en = 4'($urandom_range(0, 15));
      bus.global_ie = ($urandom_range(0, 7) != 0);
      bus.cpu_ack   = ($urandom_range(0, 2) == 0);
      bus.cpu_reti  = ($urandom_range(0, 3) == 0);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand%0d", i), model_out());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
